decode_stage: RTL and testbench

Registered, parametrised RV32/RV64 instruction decode stage between fetch and register read. It extracts all RISC-V base-format fields, classifies the format, generates the sign-extended immediate and flags illegal encodings. A valid/ready handshake with a 2-entry skid buffer sustains one instruction per cycle under backpressure, and a flush input squashes everything in flight.

---
 rtl/decode_stage.sv | 252 +++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ============================================================================
// decode_stage
//
// Registered RV32/RV64 instruction decode stage sitting between fetch and
// register read. Each incoming instruction word is decoded combinationally
// (format, sign-extended immediate, rd write-enable). The result is then
// captured either in the output register (OUT) or in a one-deep skid
// register (SKID). This sustains one instruction per cycle under
// backpressure without a combinational path from out_ready to in_ready.
//
// Parameters
//   XLEN      : datapath width of pc and imm, 32 or 64
//
// Ports
//   clk       : clock, rising-edge active
//   rst_n     : asynchronous active-low reset
//   flush     : squashes both buffered entries and drops same-cycle input
//   in_valid  : in_instr / in_pc are valid
//   in_ready  : stage can accept (driven from registered state only)
//   in_instr  : raw 32-bit instruction word
//   in_pc     : instruction address
//   out_valid : decoded entry in OUT is valid
//   out_ready : downstream accepts the OUT entry
//   out_pc    : address of the decoded instruction
//   opcode, rd, func3, rs1, rs2, func7 : raw fields of the OUT instruction
//   imm       : sign-extended immediate of the OUT instruction
//   fmt       : format code R=0 I=1 S=2 B=3 U=4 J=5 SYS=6 ILL=7
//   illegal   : fmt == ILL
//   rd_we     : instruction writes a non-zero rd
// ============================================================================
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      func7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic            rd_we
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SYS = 3'd6,
        FMT_ILL = 3'd7
    } fmt_t;

    buf_state_t      state;
    buf_state_t      state_next;

    logic            accept;
    logic            load_out_in;
    logic            load_out_skid;
    logic            load_skid;

    fmt_t            dec_fmt;
    logic [31:0]     dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic            dec_rd_we;

    logic [31:0]     out_instr_q;
    logic [XLEN-1:0] out_pc_q;
    fmt_t            out_fmt_q;
    logic [XLEN-1:0] out_imm_q;
    logic            out_rd_we_q;

    logic [31:0]     skid_instr_q;
    logic [XLEN-1:0] skid_pc_q;
    fmt_t            skid_fmt_q;
    logic [XLEN-1:0] skid_imm_q;
    logic            skid_rd_we_q;

    // Input-side decode. Every supported opcode ends in 2'b11, so any word
    // whose low two bits differ automatically lands in the default (ILL)
    // branch. All immediates fit in 32 bits once sign-extended; the 32-bit
    // value is then sign-extended once more to XLEN. This is what makes
    // the upper half of an RV64 U-immediate replicate instr[31].
    always_comb begin
        dec_fmt   = FMT_ILL;
        dec_imm32 = '0;
        dec_rd_we = 1'b0;

        case (in_instr[6:0])
            7'b0110011:                         dec_fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111: dec_fmt = FMT_I;
            7'b0100011:                         dec_fmt = FMT_S;
            7'b1100011:                         dec_fmt = FMT_B;
            7'b0110111, 7'b0010111:             dec_fmt = FMT_U;
            7'b1101111:                         dec_fmt = FMT_J;
            7'b1110011:                         dec_fmt = FMT_SYS;
            default:                            dec_fmt = FMT_ILL;
        endcase

        case (dec_fmt)
            FMT_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            FMT_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            FMT_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            FMT_U: dec_imm32 = {in_instr[31:12], 12'b0};
            FMT_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                                in_instr[20], in_instr[30:21], 1'b0};
            default: dec_imm32 = '0;
        endcase

        case (dec_fmt)
            FMT_R, FMT_I, FMT_U, FMT_J, FMT_SYS: dec_rd_we = (in_instr[11:7] != 5'd0);
            default:                             dec_rd_we = 1'b0;
        endcase
    end

    assign dec_imm = XLEN'($signed(dec_imm32));

    // Handshake flags come straight from the state register, so in_ready
    // never depends combinationally on out_ready.
    assign out_valid = (state != ST_EMPTY);
    assign in_ready  = (state != ST_FULL);
    assign accept    = in_valid & in_ready & ~flush;

    // Buffer occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and register-load decisions. Flush wins over everything.
    // When OUT drains while SKID is occupied, SKID moves forward so that
    // the older instruction always leaves first. No new input can arrive
    // in that cycle because in_ready is low in FULL.
    always_comb begin
        state_next    = state;
        load_out_in   = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;

        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        load_out_in = 1'b1;
                        state_next  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (out_ready) begin
                        if (accept) begin
                            load_out_in = 1'b1;
                        end else begin
                            state_next = ST_EMPTY;
                        end
                    end else if (accept) begin
                        load_skid  = 1'b1;
                        state_next = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_ready) begin
                        load_out_skid = 1'b1;
                        state_next    = ST_ONE;
                    end
                end
                default: begin
                    state_next = ST_EMPTY;
                end
            endcase
        end
    end

    // Output register. It only changes on a load, so the data stays stable
    // while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_instr_q <= '0;
            out_pc_q    <= '0;
            out_fmt_q   <= FMT_R;
            out_imm_q   <= '0;
            out_rd_we_q <= 1'b0;
        end else if (load_out_in) begin
            out_instr_q <= in_instr;
            out_pc_q    <= in_pc;
            out_fmt_q   <= dec_fmt;
            out_imm_q   <= dec_imm;
            out_rd_we_q <= dec_rd_we;
        end else if (load_out_skid) begin
            out_instr_q <= skid_instr_q;
            out_pc_q    <= skid_pc_q;
            out_fmt_q   <= skid_fmt_q;
            out_imm_q   <= skid_imm_q;
            out_rd_we_q <= skid_rd_we_q;
        end
    end

    // Skid register. It holds the younger instruction that arrived while
    // the downstream was stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_fmt_q   <= FMT_R;
            skid_imm_q   <= '0;
            skid_rd_we_q <= 1'b0;
        end else if (load_skid) begin
            skid_instr_q <= in_instr;
            skid_pc_q    <= in_pc;
            skid_fmt_q   <= dec_fmt;
            skid_imm_q   <= dec_imm;
            skid_rd_we_q <= dec_rd_we;
        end
    end

    assign out_pc  = out_pc_q;
    assign opcode  = out_instr_q[6:0];
    assign rd      = out_instr_q[11:7];
    assign func3   = out_instr_q[14:12];
    assign rs1     = out_instr_q[19:15];
    assign rs2     = out_instr_q[24:20];
    assign func7   = out_instr_q[31:25];
    assign imm     = out_imm_q;
    assign fmt     = out_fmt_q;
    assign illegal = (out_fmt_q == FMT_ILL);
    assign rd_we   = out_rd_we_q;

endmodule

// File: tb/tb_decode_stage.sv
// ============================================================================
// tb_decode_stage
//
// Drives an XLEN=32 and an XLEN=64 decode_stage with the same instruction
// stream. Expected values come from a capacity-2 FIFO model and an
// arithmetic immediate calculator, plus a table of hand-decoded
// instructions.
// ============================================================================
module tb_decode_stage;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } entry_t;

    typedef struct {
        logic [31:0] instr;
        int          fmt;
        logic [63:0] imm;
        bit          we;
        bit          ill;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [63:0] in_pc64;
    logic [31:0] in_pc32;
    logic        out_ready;

    logic        in_ready32, out_valid32, illegal32, rd_we32;
    logic [31:0] out_pc32, imm32;
    logic [6:0]  opcode32, func7_32;
    logic [4:0]  rd32, rs1_32, rs2_32;
    logic [2:0]  func3_32, fmt32;

    logic        in_ready64, out_valid64, illegal64, rd_we64;
    logic [63:0] out_pc64, imm64;
    logic [6:0]  opcode64, func7_64;
    logic [4:0]  rd64, rs1_64, rs2_64;
    logic [2:0]  func3_64, fmt64;

    int          test_count = 0;
    int          fail_count = 0;
    entry_t      model_q[$];
    vec_t        vecs[13];
    logic [6:0]  known_ops[10];

    assign in_pc32 = in_pc64[31:0];

    decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_pc(in_pc32),
        .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
        .opcode(opcode32), .rd(rd32), .func3(func3_32), .rs1(rs1_32),
        .rs2(rs2_32), .func7(func7_32), .imm(imm32), .fmt(fmt32),
        .illegal(illegal32), .rd_we(rd_we32)
    );

    decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_pc(in_pc64),
        .out_valid(out_valid64), .out_ready(out_ready), .out_pc(out_pc64),
        .opcode(opcode64), .rd(rd64), .func3(func3_64), .rs1(rs1_64),
        .rs2(rs2_64), .func7(func7_64), .imm(imm64), .fmt(fmt64),
        .illegal(illegal64), .rd_we(rd_we64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        test_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode built from the encoding rules: the immediate is
    // assembled as an unsigned bit pattern and made negative by subtracting
    // 2^width when the sign bit is set.
    function automatic void refDecode(input logic [31:0] w, output int f,
                                      output logic [63:0] immv, output bit we);
        longint u;
        longint v;
        u = 0;
        v = 0;
        case (w[6:0])
            7'b0110011:                         f = 0;
            7'b0010011, 7'b0000011, 7'b1100111: f = 1;
            7'b0100011:                         f = 2;
            7'b1100011:                         f = 3;
            7'b0110111, 7'b0010111:             f = 4;
            7'b1101111:                         f = 5;
            7'b1110011:                         f = 6;
            default:                            f = 7;
        endcase
        if (w[1:0] != 2'b11) f = 7;
        case (f)
            1: begin
                u = longint'(w[31:20]);
                v = w[31] ? u - 4096 : u;
            end
            2: begin
                u = longint'({w[31:25], w[11:7]});
                v = w[31] ? u - 4096 : u;
            end
            3: begin
                u = longint'({w[31], w[7], w[30:25], w[11:8], 1'b0});
                v = w[31] ? u - 8192 : u;
            end
            4: begin
                u = longint'(w[31:12]) * 4096;
                v = w[31] ? u - (longint'(1) << 32) : u;
            end
            5: begin
                u = longint'({w[31], w[19:12], w[20], w[30:21], 1'b0});
                v = w[31] ? u - (longint'(1) << 21) : u;
            end
            default: v = 0;
        endcase
        immv = v;
        we = (f inside {0, 1, 4, 5, 6}) && (w[11:7] != 5'd0);
    endfunction

    // Compares both DUTs against the FIFO model's current contents.
    task automatic model_check(input string tag);
        int          f;
        logic [63:0] e_imm;
        bit          e_we;
        logic [31:0] w;
        logic [63:0] e_fields;
        checkOutput({tag, " in_ready32"},  in_ready32,  model_q.size() < 2);
        checkOutput({tag, " in_ready64"},  in_ready64,  model_q.size() < 2);
        checkOutput({tag, " out_valid32"}, out_valid32, model_q.size() > 0);
        checkOutput({tag, " out_valid64"}, out_valid64, model_q.size() > 0);
        if (model_q.size() > 0) begin
            w = model_q[0].instr;
            refDecode(w, f, e_imm, e_we);
            e_fields = {w[6:0], w[11:7], w[14:12], w[19:15], w[24:20], w[31:25]};
            checkOutput({tag, " pc32"}, out_pc32, model_q[0].pc[31:0]);
            checkOutput({tag, " pc64"}, out_pc64, model_q[0].pc);
            checkOutput({tag, " fields32"},
                        {opcode32, rd32, func3_32, rs1_32, rs2_32, func7_32}, e_fields);
            checkOutput({tag, " fields64"},
                        {opcode64, rd64, func3_64, rs1_64, rs2_64, func7_64}, e_fields);
            checkOutput({tag, " imm32"}, imm32, e_imm[31:0]);
            checkOutput({tag, " imm64"}, imm64, e_imm);
            checkOutput({tag, " fmt32"}, fmt32, f[2:0]);
            checkOutput({tag, " fmt64"}, fmt64, f[2:0]);
            checkOutput({tag, " illegal32"}, illegal32, f == 7);
            checkOutput({tag, " illegal64"}, illegal64, f == 7);
            checkOutput({tag, " rd_we32"}, rd_we32, e_we);
            checkOutput({tag, " rd_we64"}, rd_we64, e_we);
        end
    endtask

    // One clock cycle: drive inputs just after a falling edge, check the
    // pre-edge state, advance the FIFO model across the rising edge, and
    // return at the next falling edge.
    task automatic applyStimulus(input string tag, input bit v, input logic [31:0] w,
                                 input logic [63:0] pc, input bit ordy, input bit fl);
        int n;
        in_valid  = v;
        in_instr  = w;
        in_pc64   = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        model_check(tag);
        @(posedge clk);
        n = model_q.size();
        if (fl) begin
            model_q.delete();
        end else begin
            if (ordy && n > 0) void'(model_q.pop_front());
            if (v && n < 2) model_q.push_back('{w, pc});
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] w;
        int          f;
        logic [63:0] e_imm;
        bit          e_we;

        vecs[0]  = '{32'hFFF00093, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[1]  = '{32'h00112223, 2, 64'h0000_0000_0000_0004, 1'b0, 1'b0};
        vecs[2]  = '{32'hFE000EE3, 3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0};
        vecs[3]  = '{32'h800000EF, 5, 64'hFFFF_FFFF_FFF0_0000, 1'b1, 1'b0};
        vecs[4]  = '{32'h00000000, 7, 64'h0,                   1'b0, 1'b1};
        vecs[5]  = '{32'h0000007F, 7, 64'h0,                   1'b0, 1'b1};
        vecs[6]  = '{32'h800000B7, 4, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b0};
        vecs[7]  = '{32'h002081B3, 0, 64'h0,                   1'b1, 1'b0};
        vecs[8]  = '{32'h00000073, 6, 64'h0,                   1'b0, 1'b0};
        vecs[9]  = '{32'h00000013, 1, 64'h0,                   1'b0, 1'b0};
        vecs[10] = '{32'h12345017, 4, 64'h0000_0000_1234_5000, 1'b0, 1'b0};
        vecs[11] = '{32'h00000031, 7, 64'h0,                   1'b0, 1'b1};
        vecs[12] = '{32'h0040006F, 5, 64'h0000_0000_0000_0004, 1'b0, 1'b0};

        known_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                      7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};

        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc64   = '0;
        out_ready = 1'b0;

        #2;
        checkOutput("reset out_valid32", out_valid32, 1'b0);
        checkOutput("reset out_valid64", out_valid64, 1'b0);
        checkOutput("reset in_ready32", in_ready32, 1'b1);
        checkOutput("reset in_ready64", in_ready64, 1'b1);
        checkOutput("reset data32", {out_pc32, imm32, opcode32, rd32, func3_32, rs1_32,
                                     rs2_32, func7_32, fmt32, illegal32, rd_we32}, '0);
        checkOutput("reset data64", {opcode64, rd64, func3_64, rs1_64, rs2_64, func7_64,
                                     fmt64, illegal64, rd_we64}, '0);
        checkOutput("reset pc64", out_pc64, '0);
        checkOutput("reset imm64", imm64, '0);

        @(negedge clk);
        rst_n = 1'b1;

        // Table of hand-decoded instructions streamed at full rate.
        for (int i = 0; i < 13; i++) begin
            applyStimulus("table", 1'b1, vecs[i].instr, 64'h1000 + 64'(i * 4), 1'b1, 1'b0);
            checkOutput($sformatf("table%0d fmt32", i), fmt32, vecs[i].fmt[2:0]);
            checkOutput($sformatf("table%0d fmt64", i), fmt64, vecs[i].fmt[2:0]);
            checkOutput($sformatf("table%0d imm32", i), imm32, vecs[i].imm[31:0]);
            checkOutput($sformatf("table%0d imm64", i), imm64, vecs[i].imm);
            checkOutput($sformatf("table%0d rd_we", i), {rd_we32, rd_we64}, {2{vecs[i].we}});
            checkOutput($sformatf("table%0d illegal", i), {illegal32, illegal64}, {2{vecs[i].ill}});
        end
        applyStimulus("drain", 1'b0, '0, '0, 1'b1, 1'b0);

        // Backpressure: A, B fill the buffer, C is held until space frees.
        applyStimulus("bp A", 1'b1, 32'h00100093, 64'h2000, 1'b0, 1'b0);
        applyStimulus("bp B", 1'b1, 32'h00200113, 64'h2004, 1'b0, 1'b0);
        applyStimulus("bp C held", 1'b1, 32'h00300193, 64'h2008, 1'b0, 1'b0);
        checkOutput("bp full in_ready32", in_ready32, 1'b0);
        checkOutput("bp full in_ready64", in_ready64, 1'b0);
        checkOutput("bp head pc", out_pc32, 32'h2000);
        applyStimulus("bp C release", 1'b1, 32'h00300193, 64'h2008, 1'b1, 1'b0);
        checkOutput("bp second pc", out_pc32, 32'h2004);
        applyStimulus("bp C enter", 1'b1, 32'h00300193, 64'h2008, 1'b1, 1'b0);
        checkOutput("bp third pc", out_pc32, 32'h2008);
        applyStimulus("bp drain", 1'b0, '0, '0, 1'b1, 1'b0);
        checkOutput("bp empty", {out_valid32, out_valid64}, 2'b00);

        // Flush while FULL with a valid input: everything is dropped.
        applyStimulus("fl A", 1'b1, 32'h00500293, 64'h3000, 1'b0, 1'b0);
        applyStimulus("fl B", 1'b1, 32'h00600313, 64'h3004, 1'b0, 1'b0);
        applyStimulus("fl flush", 1'b1, 32'h00700393, 64'h3008, 1'b1, 1'b1);
        checkOutput("fl out_valid", {out_valid32, out_valid64}, 2'b00);
        checkOutput("fl in_ready", {in_ready32, in_ready64}, 2'b11);
        applyStimulus("fl next", 1'b1, 32'h00800413, 64'h300C, 1'b1, 1'b0);
        checkOutput("fl next pc", out_pc64, 64'h300C);
        applyStimulus("fl drain", 1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset while FULL.
        applyStimulus("rst A", 1'b1, 32'h00900493, 64'h4000, 1'b0, 1'b0);
        applyStimulus("rst B", 1'b1, 32'h00A00513, 64'h4004, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst out_valid", {out_valid32, out_valid64}, 2'b00);
        checkOutput("async rst in_ready", {in_ready32, in_ready64}, 2'b11);
        model_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("rst first", 1'b1, 32'h800000B7, 64'h5000, 1'b1, 1'b0);
        checkOutput("rst first valid", {out_valid32, out_valid64}, 2'b11);
        checkOutput("rst first imm64", imm64, 64'hFFFF_FFFF_8000_0000);
        checkOutput("rst first fmt", fmt64, 3'd4);

        // Randomized traffic against the FIFO model.
        for (int i = 0; i < 400; i++) begin
            w = $urandom();
            if ($urandom_range(0, 3) != 0) w[6:0] = known_ops[$urandom_range(0, 9)];
            applyStimulus("rand", ($urandom_range(0, 3) != 0), w,
                          {$urandom(), $urandom()}, ($urandom_range(0, 2) != 0),
                          ($urandom_range(0, 29) == 0));
        end
        applyStimulus("rand drain1", 1'b0, '0, '0, 1'b1, 1'b0);
        applyStimulus("rand drain2", 1'b0, '0, '0, 1'b1, 1'b0);
        applyStimulus("rand drain3", 1'b0, '0, '0, 1'b1, 1'b0);

        refDecode(32'hFE000EE3, f, e_imm, e_we);
        checkOutput("ref beq sanity", e_imm, 64'hFFFF_FFFF_FFFF_FFFC);

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
